sram_arbiter: RTL and testbench

Shares one single-port synchronous SRAM between the fetch stage (instruction reads) and the mem stage (data loads and stores) of the five-stage pipeline. When both stages request in the same cycle, data wins. The block sequences each access through issue, wait and response phases, and raises one global `stall` that freezes the pipeline until every outstanding request is answered. It sits between the datapath's `PCF`/`InstF` and `MemEn`/`Sel`/`ALUOutM`/`WriteDataM`/`ReadDataM` ports and the SRAM macro.

---
 rtl/sram_arb_pkg.sv | 23 ++
 rtl/sram_arbiter.sv | 122 ++++++++++++
 tb/tb_sram_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and limits for the fetch/data SRAM arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } arb_owner_t;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 7;

  // Any byte enable set turns a data access into a store.
  function automatic logic isWrite(input logic [3:0] wen);
    return |wen;
  endfunction

endpackage

// File: rtl/sram_arbiter.sv
// Single-port SRAM shared by fetch (reads) and mem stage (loads/stores).
// Data wins collisions; every access runs issue -> (wait) -> response and
// the pipeline is stalled until each held request has seen its done pulse.
//
//   state | meaning
//   IDLE  | free to issue; arbitration happens here only
//   WAIT  | a read is outstanding, cnt counts down the SRAM latency
//   RESP  | the owner's done pulse is being driven, no issue this cycle
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        d_req,
  input  logic [3:0]  d_wen,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        stall,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  if (LAT < LAT_MIN || LAT > LAT_MAX) begin : gLatCheck
    $error("sram_arbiter: LAT must be within 1..7");
  end

  localparam logic [2:0] LAT_CNT = 3'(LAT);

  arb_state_t state;
  arb_owner_t owner;
  logic [2:0] cnt;

  logic issueNow;
  logic winD;
  logic issueWrite;
  logic outIssue;

  assign winD       = d_req;
  assign issueNow   = (state == IDLE) & (if_req | d_req);
  assign issueWrite = winD & isWrite(d_wen);
  // Keep the SRAM strobe quiet while reset is held, even though IDLE sees requests.
  assign outIssue   = issueNow & rst;

  // Route the winning requester straight to the macro in the issue cycle; idle bus is zero.
  always_comb begin
    sram_en    = outIssue;
    sram_wen   = 4'b0000;
    sram_addr  = 32'h0000_0000;
    sram_wdata = 32'h0000_0000;
    if (outIssue) begin
      if (winD) begin
        sram_wen   = d_wen;
        sram_addr  = d_addr;
        sram_wdata = d_wdata;
      end else begin
        sram_addr  = if_addr;
      end
    end
  end

  // A held request stalls until its own done pulse arrives.
  assign stall = (if_req & ~if_done) | (d_req & ~d_done);

  // Access sequencer: owner tracking, latency countdown, read capture and done pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      owner    <= OWN_IF;
      cnt      <= 3'd0;
      if_done  <= 1'b0;
      d_done   <= 1'b0;
      if_rdata <= 32'h0000_0000;
      d_rdata  <= 32'h0000_0000;
    end else begin
      case (state)
        IDLE: begin
          if (issueNow) begin
            owner <= winD ? OWN_D : OWN_IF;
            if (issueWrite) begin
              state  <= RESP;
              d_done <= 1'b1;
            end else begin
              cnt   <= LAT_CNT;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            state <= RESP;
            if (owner == OWN_D) begin
              d_rdata <= sram_rdata;
              d_done  <= 1'b1;
            end else begin
              if_rdata <= sram_rdata;
              if_done  <= 1'b1;
            end
          end
        end
        RESP: begin
          if_done <= 1'b0;
          d_done  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Two arbiters (LAT=1 and LAT=4) driven by directed scenarios then random
// requesters, checked every cycle against a transaction-level model.
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  logic        ifReq[2];
  logic [31:0] ifAddr[2];
  logic [31:0] ifRdata[2];
  logic        ifDone[2];
  logic        dReq[2];
  logic [3:0]  dWen[2];
  logic [31:0] dAddr[2];
  logic [31:0] dWdata[2];
  logic [31:0] dRdata[2];
  logic        dDone[2];
  logic        stall[2];
  logic        sramEn[2];
  logic [3:0]  sramWen[2];
  logic [31:0] sramAddr[2];
  logic [31:0] sramWdata[2];
  logic [31:0] sramRdata[2];

  sram_arbiter #(.LAT(1)) dut0 (
    .clk(clk), .rst(rst),
    .if_req(ifReq[0]), .if_addr(ifAddr[0]), .if_rdata(ifRdata[0]), .if_done(ifDone[0]),
    .d_req(dReq[0]), .d_wen(dWen[0]), .d_addr(dAddr[0]), .d_wdata(dWdata[0]),
    .d_rdata(dRdata[0]), .d_done(dDone[0]), .stall(stall[0]),
    .sram_en(sramEn[0]), .sram_wen(sramWen[0]), .sram_addr(sramAddr[0]),
    .sram_wdata(sramWdata[0]), .sram_rdata(sramRdata[0])
  );

  sram_arbiter #(.LAT(4)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(ifReq[1]), .if_addr(ifAddr[1]), .if_rdata(ifRdata[1]), .if_done(ifDone[1]),
    .d_req(dReq[1]), .d_wen(dWen[1]), .d_addr(dAddr[1]), .d_wdata(dWdata[1]),
    .d_rdata(dRdata[1]), .d_done(dDone[1]), .stall(stall[1]),
    .sram_en(sramEn[1]), .sram_wen(sramWen[1]), .sram_addr(sramAddr[1]),
    .sram_wdata(sramWdata[1]), .sram_rdata(sramRdata[1])
  );

  function automatic int latOf(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] nw,
                                             input logic [3:0] wen);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (wen[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d cyc=%0d actual=%h expected=%h", nm, k, cyc, act, exp);
    end
  endtask

  task automatic chkB(input string nm, input int k, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d cyc=%0d actual=%b expected=%b", nm, k, cyc, act, exp);
    end
  endtask

  // SRAM macro behaviour: writes land at the strobe, read data appears exactly LAT cycles later.
  logic [31:0] envMem[2][256];
  bit          pendValid[2];
  int          pendDue[2];
  logic [31:0] pendData[2];
  int          envIdx;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst) pendValid[k] = 1'b0;
      else if (sramEn[k] === 1'b1) begin
        envIdx = int'(sramAddr[k][9:2]);
        if (sramWen[k] != 4'b0000)
          envMem[k][envIdx] = mergeBytes(envMem[k][envIdx], sramWdata[k], sramWen[k]);
        else begin
          pendValid[k] = 1'b1;
          pendDue[k]   = cyc + latOf(k);
          pendData[k]  = envMem[k][envIdx];
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++)
      sramRdata[k] = (pendValid[k] && pendDue[k] == cyc) ? pendData[k] : $urandom;
  end

  // Reference model: one access at a time, busy from issue through its done cycle.
  logic [31:0] refMem[2][256];
  bit          mBusy[2];
  int          mDoneCyc[2];
  bit          mOwnD[2];
  bit          mRead[2];
  logic [31:0] mData[2];
  logic [31:0] expIfR[2];
  logic [31:0] expDR[2];
  bit          lastIfDone[2];
  bit          lastDDone[2];

  always @(negedge clk) begin
    bit eIf, eD, eIssue, own, wr;
    logic [31:0] a;
    int idx;
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        mBusy[k]  = 1'b0;
        expIfR[k] = 32'h0;
        expDR[k]  = 32'h0;
        chkB("rst_en", k, sramEn[k], 1'b0);
        chk("rst_wen", k, 32'(sramWen[k]), 32'h0);
        chkB("rst_ifdone", k, ifDone[k], 1'b0);
        chkB("rst_ddone", k, dDone[k], 1'b0);
        chk("rst_ifrdata", k, ifRdata[k], 32'h0);
        chk("rst_drdata", k, dRdata[k], 32'h0);
        chkB("rst_stall", k, stall[k], ifReq[k] | dReq[k]);
      end else begin
        if (mBusy[k] && cyc > mDoneCyc[k]) mBusy[k] = 1'b0;
        eIf = mBusy[k] && cyc == mDoneCyc[k] && !mOwnD[k];
        eD  = mBusy[k] && cyc == mDoneCyc[k] && mOwnD[k];
        if (eIf && mRead[k]) expIfR[k] = mData[k];
        if (eD && mRead[k])  expDR[k]  = mData[k];
        eIssue = !mBusy[k] && (ifReq[k] || dReq[k]);
        chkB("en", k, sramEn[k], eIssue);
        chkB("addr_known", k, $isunknown(sramAddr[k]) | $isunknown(sramWdata[k]), 1'b0);
        if (eIssue) begin
          own = dReq[k];
          a   = own ? dAddr[k] : ifAddr[k];
          wr  = own && dWen[k] != 4'b0000;
          chk("issue_addr", k, sramAddr[k], a);
          chk("issue_wen", k, 32'(sramWen[k]), own ? 32'(dWen[k]) : 32'h0);
          if (own) chk("issue_wdata", k, sramWdata[k], dWdata[k]);
          idx = int'(a[9:2]);
          if (wr) refMem[k][idx] = mergeBytes(refMem[k][idx], dWdata[k], dWen[k]);
          else    mData[k] = refMem[k][idx];
          mBusy[k]    = 1'b1;
          mOwnD[k]    = own;
          mRead[k]    = !wr;
          mDoneCyc[k] = cyc + (wr ? 1 : latOf(k) + 1);
        end else begin
          chk("idle_wen", k, 32'(sramWen[k]), 32'h0);
        end
        chkB("if_done", k, ifDone[k], eIf);
        chkB("d_done", k, dDone[k], eD);
        chk("if_rdata", k, ifRdata[k], expIfR[k]);
        chk("d_rdata", k, dRdata[k], expDR[k]);
        chkB("stall", k, stall[k], (ifReq[k] & ~eIf) | (dReq[k] & ~eD));
      end
      lastIfDone[k] = ifDone[k];
      lastDDone[k]  = dDone[k];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearReqs();
    for (int k = 0; k < 2; k++) begin
      ifReq[k] = 1'b0;
      dReq[k]  = 1'b0;
    end
  endtask

  task automatic presetWord(input int k, input logic [31:0] addr, input logic [31:0] v);
    envMem[k][int'(addr[9:2])] = v;
    refMem[k][int'(addr[9:2])] = v;
  endtask

  // Random requester: holds each request until its done, then may chain a new one.
  task automatic agent(input int k);
    if (lastIfDone[k]) begin
      if ($urandom_range(1, 0) == 1) ifAddr[k] = $urandom;
      else ifReq[k] = 1'b0;
    end else if (!ifReq[k] && $urandom_range(2, 0) == 0) begin
      ifReq[k]  = 1'b1;
      ifAddr[k] = $urandom;
    end
    if (lastDDone[k] && $urandom_range(1, 0) == 0) dReq[k] = 1'b0;
    else if ((lastDDone[k] || !dReq[k]) && $urandom_range(2, 0) == 0) begin
      dReq[k]   = 1'b1;
      dAddr[k]  = $urandom;
      dWdata[k] = $urandom;
      dWen[k]   = ($urandom_range(1, 0) == 1) ? 4'b0000 : 4'($urandom_range(15, 1));
    end else if (lastDDone[k]) begin
      dReq[k] = 1'b0;
    end
  endtask

  initial begin
    int rstHold;
    for (int k = 0; k < 2; k++) begin
      ifAddr[k] = 32'h0; dWen[k] = 4'h0; dAddr[k] = 32'h0; dWdata[k] = 32'h0;
      sramRdata[k] = 32'h0;
      for (int i = 0; i < 256; i++) begin
        envMem[k][i] = $urandom;
        refMem[k][i] = envMem[k][i];
      end
    end
    clearReqs();
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    step();
    rst = 1'b1;

    // Fetch only, LAT=1
    presetWord(0, 32'hBFC0_0000, 32'h2408_0001);
    step();
    ifReq[0] = 1'b1; ifAddr[0] = 32'hBFC0_0000;
    @(negedge clk);
    chkB("lit_fetch_en0", 0, sramEn[0], 1'b1);
    chkB("lit_fetch_stall0", 0, stall[0], 1'b1);
    step();
    @(negedge clk);
    chkB("lit_fetch_en1", 0, sramEn[0], 1'b0);
    chkB("lit_fetch_stall1", 0, stall[0], 1'b1);
    step();
    @(negedge clk);
    chkB("lit_fetch_done", 0, ifDone[0], 1'b1);
    chk("lit_fetch_rdata", 0, ifRdata[0], 32'h2408_0001);
    chkB("lit_fetch_stall2", 0, stall[0], 1'b0);
    step();
    ifReq[0] = 1'b0;

    // Store, then read back the merged word
    step();
    dReq[0] = 1'b1; dWen[0] = 4'b0011; dAddr[0] = 32'h8000_1002; dWdata[0] = 32'h0000_BEEF;
    @(negedge clk);
    chk("lit_store_wen", 0, 32'(sramWen[0]), 32'h3);
    step();
    @(negedge clk);
    chkB("lit_store_done", 0, dDone[0], 1'b1);
    step();
    dWen[0] = 4'b0000; dAddr[0] = 32'h8000_1000;
    step();
    step();
    @(negedge clk);
    chkB("lit_load_done", 0, dDone[0], 1'b1);
    chk("lit_load_rdata", 0, dRdata[0], 32'h2408_BEEF);
    step();
    dReq[0] = 1'b0;

    // Collision, LAT=1
    step();
    ifReq[0] = 1'b1; ifAddr[0] = 32'h0000_0040;
    dReq[0] = 1'b1; dWen[0] = 4'b0000; dAddr[0] = 32'h0000_0080;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) step();
      if (c == 3) dReq[0] = 1'b0;
      @(negedge clk);
      chkB("lit_col_en", 0, sramEn[0], c == 0 || c == 3);
      chkB("lit_col_ddone", 0, dDone[0], c == 2);
      chkB("lit_col_ifdone", 0, ifDone[0], c == 5);
      chkB("lit_col_stall", 0, stall[0], c < 5);
      if (c == 0) chk("lit_col_addr0", 0, sramAddr[0], 32'h0000_0080);
      if (c == 3) chk("lit_col_addr3", 0, sramAddr[0], 32'h0000_0040);
    end
    step();
    ifReq[0] = 1'b0;

    // LAT=4 load
    presetWord(1, 32'h0000_0100, 32'h1234_5678);
    step();
    dReq[1] = 1'b1; dWen[1] = 4'b0000; dAddr[1] = 32'h0000_0100;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) step();
      if (c == 6) dReq[1] = 1'b0;
      @(negedge clk);
      chkB("lit_l4_en", 1, sramEn[1], c == 0);
      chkB("lit_l4_done", 1, dDone[1], c == 5);
      chkB("lit_l4_stall", 1, stall[1], c < 5);
      if (c == 5) chk("lit_l4_rdata", 1, dRdata[1], 32'h1234_5678);
    end

    // Back-to-back fetches, LAT=4
    presetWord(1, 32'h0000_0200, 32'hA5A5_0001);
    presetWord(1, 32'h0000_0204, 32'hA5A5_0002);
    step();
    ifReq[1] = 1'b1; ifAddr[1] = 32'h0000_0200;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) step();
      if (c == 6) ifAddr[1] = 32'h0000_0204;
      @(negedge clk);
      chkB("lit_b2b_en", 1, sramEn[1], c == 0 || c == 6);
      chkB("lit_b2b_done", 1, ifDone[1], c == 5 || c == 11);
      if (c == 5)  chk("lit_b2b_rdata0", 1, ifRdata[1], 32'hA5A5_0001);
      if (c == 11) chk("lit_b2b_rdata1", 1, ifRdata[1], 32'hA5A5_0002);
    end
    step();
    ifReq[1] = 1'b0;

    // Reset two cycles into a LAT=4 read
    step();
    dReq[1] = 1'b1; dWen[1] = 4'b0000; dAddr[1] = 32'h0000_0100;
    step();
    step();
    rst = 1'b0;
    dReq[1] = 1'b0;
    @(negedge clk);
    chkB("lit_rst_en", 1, sramEn[1], 1'b0);
    chkB("lit_rst_ddone", 1, dDone[1], 1'b0);
    chk("lit_rst_drdata", 1, dRdata[1], 32'h0);
    chk("lit_rst_ifrdata", 1, ifRdata[1], 32'h0);
    step();
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chkB("lit_post_rst_done", 1, dDone[1] | ifDone[1], 1'b0);
      chkB("lit_post_rst_en", 1, sramEn[1], 1'b0);
      step();
    end

    // Random traffic with occasional resets
    rstHold = 0;
    for (int n = 0; n < 3000; n++) begin
      step();
      if (rstHold > 0) begin
        rstHold--;
        if (rstHold == 0) rst = 1'b1;
      end else if ($urandom_range(199, 0) == 0) begin
        rst = 1'b0;
        rstHold = 2;
        clearReqs();
      end else begin
        for (int k = 0; k < 2; k++) agent(k);
      end
    end
    clearReqs();
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
